// File: rtl/alu_control_multicycle.sv
// alu_control_multicycle: MIPS ALUOp/funct decode and execute with valid/ready handshake and iterative MULTU
//   in:  clk, reset (sync, active-high), in_valid, alu_op[2:0], alu_function[5:0], a, b, shamt, out_ready
//   out: in_ready (IDLE), out_valid (DONE), result, result_hi (MULTU high half), zero, jr, illegal
module alu_control_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            alu_op,
  input  logic [5:0]            alu_function,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  zero,
  output logic                  jr,
  output logic                  illegal
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] nres, mcand;
  logic njr, nill, nmul;
  logic [SHAMT_W-1:0] cnt;
  logic [2*DATA_WIDTH-1:0] acc, nacc;
  logic [DATA_WIDTH:0] sum;
  always_comb begin
    nres = '0;
    njr = 1'b0;
    nill = 1'b0;
    nmul = 1'b0;
    case (alu_op)
      3'b100: nres = a + b;
      3'b101: nres = a | b;
      3'b110: nres = a & b;
      3'b001: nres = a - b;
      3'b011: nres = b << (DATA_WIDTH / 2);
      3'b111:
        case (alu_function)
          6'h24: nres = a & b;
          6'h25: nres = a | b;
          6'h27: nres = ~(a | b);
          6'h20: nres = a + b;
          6'h22: nres = a - b;
          6'h00: nres = b << shamt;
          6'h02: nres = b >> shamt;
          6'h08: begin
            nres = a;
            njr = 1'b1;
          end
          6'h19: nmul = 1'b1;
          default: nill = 1'b1;
        endcase
      default: nill = 1'b1;
    endcase
  end
  // Shift-add step: low half holds the remaining multiplier bits, high half accumulates with carry-out kept
  always_comb begin
    sum = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, mcand & {DATA_WIDTH{acc[0]}}};
    nacc = {sum, acc[DATA_WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= '0;
      result_hi <= '0;
      zero <= 1'b0;
      jr <= 1'b0;
      illegal <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            in_ready <= 1'b0;
            if (nmul) begin
              state <= MUL;
              cnt <= '0;
              mcand <= a;
              acc <= {{DATA_WIDTH{1'b0}}, b};
            end else begin
              state <= DONE;
              out_valid <= 1'b1;
              result <= nres;
              result_hi <= '0;
              zero <= nres == '0;
              jr <= njr;
              illegal <= nill;
            end
          end
        MUL: begin
          acc <= nacc;
          cnt <= cnt + 1'b1;
          if (cnt == SHAMT_W'(DATA_WIDTH - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= nacc[DATA_WIDTH-1:0];
            result_hi <= nacc[2*DATA_WIDTH-1:DATA_WIDTH];
            zero <= nacc[DATA_WIDTH-1:0] == '0;
            jr <= 1'b0;
            illegal <= 1'b0;
          end
        end
        DONE:
          if (out_ready) begin
            state <= IDLE;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
